spc700_bus_ctrl: RTL and testbench

- Bus sequencer sitting directly downstream of the SPC700 address generator.
- Selects the cycle address from PC, AX or the stack page, then routes the access to ARAM, the IPL ROM overlay or the $F0-$FF I/O page.
- Runs the ARAM request/acknowledge handshake and returns read data to the core.
- Issues the single-cycle EN pulse that advances the core and the address generator.

---
 rtl/spc700_bus_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spc700_bus_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spc700_bus_ctrl.sv
// SPC700 bus sequencer: selects the slot address, routes it to ARAM, the IPL ROM
// overlay or the $F0-$FF I/O page, runs the ARAM handshake and issues the EN pulse.
module spc700_bus_ctrl #(
  parameter logic [7:0]  IO_PAGE      = 8'hF0,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [1:0]  ADDR_SEL,
  input  logic [15:0] PC,
  input  logic [15:0] AX,
  input  logic [7:0]  S,
  input  logic        WE,
  input  logic [7:0]  DO,
  input  logic        IPL_EN,
  output logic        EN,
  output logic [7:0]  D_IN,
  output logic [15:0] A,
  output logic        RAM_REQ,
  output logic        RAM_WE,
  output logic [15:0] RAM_ADDR,
  output logic [7:0]  RAM_DOUT,
  input  logic        RAM_ACK,
  input  logic [7:0]  RAM_DIN,
  output logic [5:0]  IPL_ADDR,
  input  logic [7:0]  IPL_DATA,
  output logic [3:0]  IO_ADDR,
  output logic        IO_RD,
  output logic        IO_WR,
  output logic [7:0]  IO_DOUT,
  input  logic [7:0]  IO_DIN,
  output logic        TIMEOUT,
  output logic        LATE
);

  // The wait counter runs 0..WAIT_TIMEOUT-1 while a request is outstanding.
  localparam int unsigned CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IPL,
    ST_IO,
    ST_RAM,
    ST_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_a, w_a_nxt;
  logic          r_we, w_we_nxt;
  logic [7:0]    r_do, w_do_nxt;
  logic [7:0]    r_d_in, w_d_in_nxt;
  logic          r_ram_req, w_ram_req_nxt;
  logic          r_ram_we, w_ram_we_nxt;
  logic [15:0]   r_ram_addr, w_ram_addr_nxt;
  logic [7:0]    r_ram_dout, w_ram_dout_nxt;
  logic [CW-1:0] r_wait, w_wait_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          r_late, w_late_nxt;

  logic [15:0]   w_slot_addr;
  logic          w_is_io;
  logic          w_is_ipl;

  always_comb begin
    w_slot_addr = r_a;
    case (ADDR_SEL)
      2'b00:   w_slot_addr = PC;
      2'b01:   w_slot_addr = AX;
      2'b10:   w_slot_addr = {8'h01, S};
      default: w_slot_addr = r_a;
    endcase
    w_is_io  = (w_slot_addr[15:4] == {8'h00, IO_PAGE[7:4]});
    // Writes into the ROM window always fall through to ARAM.
    w_is_ipl = !WE && IPL_EN && (w_slot_addr >= 16'hFFC0);
  end

  // ARAM handshake: RAM_REQ is a level held together with RAM_WE/RAM_ADDR/RAM_DOUT
  // unchanged until the first edge on which RAM_ACK is high; that edge completes
  // the transfer and RAM_ACK is ignored whenever RAM_REQ is low.
  always_comb begin
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_we_nxt       = r_we;
    w_do_nxt       = r_do;
    w_d_in_nxt     = r_d_in;
    w_ram_req_nxt  = r_ram_req;
    w_ram_we_nxt   = r_ram_we;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_dout_nxt = r_ram_dout;
    w_wait_nxt     = r_wait;
    w_timeout_nxt  = r_timeout;
    w_late_nxt     = r_late | (CE && (r_state != ST_IDLE));

    case (r_state)
      ST_IDLE: begin
        if (CE) begin
          w_a_nxt  = w_slot_addr;
          w_we_nxt = WE;
          w_do_nxt = DO;
          if (w_is_io) begin
            w_state_nxt = ST_IO;
          end else if (w_is_ipl) begin
            w_state_nxt = ST_IPL;
          end else begin
            w_state_nxt    = ST_RAM;
            w_ram_req_nxt  = 1'b1;
            w_ram_we_nxt   = WE;
            w_ram_addr_nxt = w_slot_addr;
            w_ram_dout_nxt = DO;
            w_wait_nxt     = '0;
          end
        end
      end
      ST_IPL: begin
        w_d_in_nxt  = IPL_DATA;
        w_state_nxt = ST_DONE;
      end
      ST_IO: begin
        if (r_we) begin
          // Register writes are mirrored into ARAM at the same address.
          w_state_nxt    = ST_RAM;
          w_ram_req_nxt  = 1'b1;
          w_ram_we_nxt   = 1'b1;
          w_ram_addr_nxt = r_a;
          w_ram_dout_nxt = r_do;
          w_wait_nxt     = '0;
        end else begin
          w_d_in_nxt  = IO_DIN;
          w_state_nxt = ST_DONE;
        end
      end
      ST_RAM: begin
        if (r_ram_req && RAM_ACK) begin
          w_ram_req_nxt = 1'b0;
          w_ram_we_nxt  = 1'b0;
          if (!r_we) w_d_in_nxt = RAM_DIN;
          w_state_nxt = ST_DONE;
        end else if (r_wait == WAIT_LAST) begin
          w_ram_req_nxt = 1'b0;
          w_ram_we_nxt  = 1'b0;
          if (!r_we) w_d_in_nxt = 8'hFF;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end else begin
          w_wait_nxt = r_wait + CW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_we       <= 1'b0;
      r_do       <= '0;
      r_d_in     <= 8'hFF;
      r_ram_req  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_dout <= '0;
      r_wait     <= '0;
      r_timeout  <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_we       <= w_we_nxt;
      r_do       <= w_do_nxt;
      r_d_in     <= w_d_in_nxt;
      r_ram_req  <= w_ram_req_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_dout <= w_ram_dout_nxt;
      r_wait     <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
      r_late     <= w_late_nxt;
    end
  end

  assign EN       = (r_state == ST_DONE);
  assign D_IN     = r_d_in;
  assign A        = r_a;
  assign RAM_REQ  = r_ram_req;
  assign RAM_WE   = r_ram_we;
  assign RAM_ADDR = r_ram_addr;
  assign RAM_DOUT = r_ram_dout;
  assign IPL_ADDR = r_a[5:0];
  assign IO_ADDR  = r_a[3:0];
  assign IO_RD    = (r_state == ST_IO) && !r_we;
  assign IO_WR    = (r_state == ST_IO) && r_we;
  assign IO_DOUT  = r_do;
  assign TIMEOUT  = r_timeout;
  assign LATE     = r_late;

endmodule

// File: tb/tb_spc700_bus_ctrl.sv
// Bench for spc700_bus_ctrl: directed plus random bus slots checked against a
// transaction-level model of routing, latency, read data and sticky flags.
module tb_spc700_bus_ctrl;

  localparam int WT    = 4;
  localparam int K_RAM = 0;
  localparam int K_IPL = 1;
  localparam int K_IO  = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic [1:0]  ADDR_SEL;
  logic [15:0] PC;
  logic [15:0] AX;
  logic [7:0]  S;
  logic        WE;
  logic [7:0]  DO;
  logic        IPL_EN;
  logic        EN;
  logic [7:0]  D_IN;
  logic [15:0] A;
  logic        RAM_REQ;
  logic        RAM_WE;
  logic [15:0] RAM_ADDR;
  logic [7:0]  RAM_DOUT;
  logic        RAM_ACK;
  logic [7:0]  RAM_DIN;
  logic [5:0]  IPL_ADDR;
  logic [7:0]  IPL_DATA;
  logic [3:0]  IO_ADDR;
  logic        IO_RD;
  logic        IO_WR;
  logic [7:0]  IO_DOUT;
  logic [7:0]  IO_DIN;
  logic        TIMEOUT;
  logic        LATE;

  logic [7:0]  ram_mem   [65536];
  logic [7:0]  model_mem [65536];
  logic [7:0]  rom       [64];
  logic [7:0]  io_regs   [16];
  logic [7:0]  exp_q[$];

  logic [15:0] model_a;
  logic [7:0]  model_din;
  logic        model_tmo;
  logic        model_late;
  int          n_checks = 0;
  int          n_errors = 0;

  spc700_bus_ctrl #(.IO_PAGE(8'hF0), .WAIT_TIMEOUT(WT)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .ADDR_SEL(ADDR_SEL), .PC(PC), .AX(AX), .S(S),
    .WE(WE), .DO(DO), .IPL_EN(IPL_EN), .EN(EN), .D_IN(D_IN), .A(A),
    .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DOUT(RAM_DOUT),
    .RAM_ACK(RAM_ACK), .RAM_DIN(RAM_DIN), .IPL_ADDR(IPL_ADDR), .IPL_DATA(IPL_DATA),
    .IO_ADDR(IO_ADDR), .IO_RD(IO_RD), .IO_WR(IO_WR), .IO_DOUT(IO_DOUT), .IO_DIN(IO_DIN),
    .TIMEOUT(TIMEOUT), .LATE(LATE)
  );

  assign IPL_DATA = rom[IPL_ADDR];
  assign IO_DIN   = io_regs[IO_ADDR];

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    CE = 1'b0;
    RAM_ACK = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_a    = 16'h0000;
    model_din  = 8'hFF;
    model_tmo  = 1'b0;
    model_late = 1'b0;
  endtask

  task automatic scramble_inputs();
    ADDR_SEL = 2'($urandom_range(0, 3));
    PC       = 16'($urandom);
    AX       = 16'($urandom);
    S        = 8'($urandom);
    WE       = 1'($urandom);
    DO       = 8'($urandom);
    IPL_EN   = 1'($urandom);
  endtask

  // One bus slot: the model predicts, the driver runs it and answers ARAM,
  // then every observation is compared with the prediction.
  task automatic access(input logic [1:0] sel, input logic [15:0] pc_v, input logic [15:0] ax_v,
                        input logic [7:0] s_v, input logic we_v, input logic [7:0] do_v,
                        input logic ipl_v, input int ack_d, input bit late_ce);
    logic [15:0] ea;
    int          kind;
    bit          ram_used, tmo;
    int          exp_req, exp_en;
    logic [7:0]  exp_din, exp_d;
    int          en_cnt, en_cyc, req_cyc, rd_cnt, wr_cnt, cycle;
    logic [15:0] rq_addr;
    logic        rq_we;
    logic [7:0]  rq_dout;
    bit          steady;
    logic [3:0]  io_a;
    logic [7:0]  io_d;
    logic [5:0]  ipl_a;

    case (sel)
      2'b00:   ea = pc_v;
      2'b01:   ea = ax_v;
      2'b10:   ea = {8'h01, s_v};
      default: ea = model_a;
    endcase
    if (ea >= 16'h00F0 && ea <= 16'h00FF)     kind = K_IO;
    else if (!we_v && ipl_v && ea >= 16'hFFC0) kind = K_IPL;
    else                                       kind = K_RAM;
    ram_used = (kind == K_RAM) || (kind == K_IO && we_v);
    tmo      = ram_used && (ack_d >= WT);
    exp_req  = !ram_used ? 0 : (tmo ? WT : ack_d + 1);
    if (!ram_used)         exp_en = 2;
    else if (kind == K_IO) exp_en = 1 + (tmo ? WT + 1 : ack_d + 2);
    else                   exp_en = tmo ? WT + 1 : ack_d + 2;
    if (we_v)              exp_din = model_din;
    else if (kind == K_IPL) exp_din = rom[ea[5:0]];
    else if (kind == K_IO)  exp_din = io_regs[ea[3:0]];
    else                    exp_din = tmo ? 8'hFF : model_mem[ea];
    if (we_v && ram_used && !tmo) model_mem[ea] = do_v;
    model_a    = ea;
    model_din  = exp_din;
    model_tmo  = model_tmo | tmo;
    model_late = model_late | late_ce;
    exp_q.push_back(exp_din);

    // driver
    @(negedge CLK);
    CE = 1'b1; ADDR_SEL = sel; PC = pc_v; AX = ax_v; S = s_v; WE = we_v; DO = do_v; IPL_EN = ipl_v;
    @(negedge CLK);
    CE = 1'b0;
    scramble_inputs();
    en_cnt = 0; en_cyc = 0; req_cyc = 0; rd_cnt = 0; wr_cnt = 0; steady = 1'b1;
    rq_addr = '0; rq_we = 1'b0; rq_dout = '0; io_a = '0; io_d = '0; ipl_a = '0;
    cycle = 1;
    while (cycle <= 40) begin
      if (EN) begin
        en_cnt++;
        if (en_cnt == 1) en_cyc = cycle;
      end
      if (RAM_REQ) begin
        req_cyc++;
        if (req_cyc == 1) begin
          rq_addr = RAM_ADDR; rq_we = RAM_WE; rq_dout = RAM_DOUT;
        end else if (RAM_ADDR !== rq_addr || RAM_WE !== rq_we || RAM_DOUT !== rq_dout) begin
          steady = 1'b0;
        end
      end
      if (IO_RD) begin rd_cnt++; io_a = IO_ADDR; end
      if (IO_WR) begin wr_cnt++; io_a = IO_ADDR; io_d = IO_DOUT; end
      if (cycle == 1) ipl_a = IPL_ADDR;
      RAM_ACK = 1'b0;
      RAM_DIN = 8'($urandom);
      if (RAM_REQ && req_cyc == ack_d + 1) begin
        RAM_ACK = 1'b1;
        RAM_DIN = ram_mem[RAM_ADDR];
        if (RAM_WE) ram_mem[RAM_ADDR] = RAM_DOUT;
      end
      CE = (late_ce && cycle == 2);
      if (en_cnt > 0 && cycle >= en_cyc + 2) break;
      @(negedge CLK);
      cycle++;
    end
    RAM_ACK = 1'b0;
    CE = 1'b0;

    // scoreboard
    exp_d = exp_q.pop_front();
    check("en_count",   32'(en_cnt),  32'(1));
    check("en_latency", 32'(en_cyc),  32'(exp_en));
    check("d_in",       32'(D_IN),    32'(exp_d));
    check("addr_a",     32'(A),       32'(ea));
    check("req_cycles", 32'(req_cyc), 32'(exp_req));
    check("io_rd_cnt",  32'(rd_cnt),  32'((kind == K_IO && !we_v) ? 1 : 0));
    check("io_wr_cnt",  32'(wr_cnt),  32'((kind == K_IO && we_v) ? 1 : 0));
    if (ram_used) begin
      check("ram_addr",   32'(rq_addr), 32'(ea));
      check("ram_we",     32'(rq_we),   32'(we_v));
      check("ram_steady", 32'(steady),  32'(1));
      check("ram_content", 32'(ram_mem[ea]), 32'(model_mem[ea]));
      if (we_v) check("ram_dout", 32'(rq_dout), 32'(do_v));
    end
    if (kind == K_IO) begin
      check("io_addr", 32'(io_a), 32'(ea[3:0]));
      if (we_v) check("io_dout", 32'(io_d), 32'(do_v));
    end
    if (kind == K_IPL) check("ipl_addr", 32'(ipl_a), 32'(ea[5:0]));
    check("timeout_flag", 32'(TIMEOUT), 32'(model_tmo));
    check("late_flag",    32'(LATE),    32'(model_late));
  endtask

  initial begin
    logic [15:0] ra;
    RST = 1'b0; CE = 1'b0; RAM_ACK = 1'b0; RAM_DIN = 8'h00;
    ADDR_SEL = 2'b00; PC = '0; AX = '0; S = '0; WE = 1'b0; DO = '0; IPL_EN = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i]   = 8'($urandom);
      model_mem[i] = ram_mem[i];
    end
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) io_regs[i] = 8'($urandom);

    // reset state
    apply_reset();
    check("rst_en",       32'(EN),       32'(0));
    check("rst_d_in",     32'(D_IN),     32'(8'hFF));
    check("rst_a",        32'(A),        32'(0));
    check("rst_ram_req",  32'(RAM_REQ),  32'(0));
    check("rst_ram_we",   32'(RAM_WE),   32'(0));
    check("rst_ram_addr", 32'(RAM_ADDR), 32'(0));
    check("rst_io_strb",  32'({IO_RD, IO_WR}), 32'(0));
    check("rst_flags",    32'({TIMEOUT, LATE}), 32'(0));

    // RAM read, ACK three cycles after REQ
    ram_mem[16'h0200] = 8'h5A; model_mem[16'h0200] = 8'h5A;
    access(2'b00, 16'h0200, 16'h1234, 8'h00, 1'b0, 8'h00, 1'b0, 3, 1'b0);
    // IPL overlay, then same address with the overlay off
    rom[5] = 8'hCD;
    access(2'b01, 16'h0000, 16'hFFC5, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    access(2'b01, 16'h0000, 16'hFFC5, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b0);
    // write into ROM window with the overlay on goes to ARAM
    access(2'b01, 16'h0000, 16'hFFD0, 8'h00, 1'b1, 8'h77, 1'b1, 0, 1'b0);
    access(2'b01, 16'h0000, 16'hFFD0, 8'h00, 1'b0, 8'h00, 1'b0, 2, 1'b0);
    // IO write-through, IO read, IO page edges
    access(2'b01, 16'h0000, 16'h00F4, 8'h00, 1'b1, 8'h33, 1'b0, 2, 1'b0);
    access(2'b00, 16'h00F7, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    access(2'b00, 16'h00EF, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    access(2'b00, 16'h0100, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    access(2'b01, 16'h0000, 16'h00FF, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    // stack write, then hold-address read back
    access(2'b10, 16'h0000, 16'h0000, 8'hEF, 1'b1, 8'h12, 1'b0, 0, 1'b0);
    access(2'b11, 16'h4444, 16'h5555, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b0);
    // timeout on read and on write, then a normal access keeps TIMEOUT
    access(2'b00, 16'h3000, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 10, 1'b0);
    access(2'b00, 16'h3001, 16'h0000, 8'h00, 1'b1, 8'hA5, 1'b0, WT, 1'b0);
    access(2'b00, 16'h3002, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, WT - 1, 1'b0);
    // CE during the RAM wait
    access(2'b00, 16'h2000, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 3, 1'b1);

    // reset in the middle of a RAM wait; a later ACK must not complete anything
    @(negedge CLK);
    CE = 1'b1; ADDR_SEL = 2'b00; PC = 16'h2222; WE = 1'b0; IPL_EN = 1'b0;
    @(negedge CLK);
    CE = 1'b0;
    check("midrst_req_up", 32'(RAM_REQ), 32'(1));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_a = 16'h0000; model_din = 8'hFF; model_tmo = 1'b0; model_late = 1'b0;
    check("midrst_req",  32'(RAM_REQ), 32'(0));
    check("midrst_en",   32'(EN),      32'(0));
    check("midrst_d_in", 32'(D_IN),    32'(8'hFF));
    check("midrst_flags", 32'({TIMEOUT, LATE}), 32'(0));
    RAM_ACK = 1'b1; RAM_DIN = 8'h5A;
    @(negedge CLK);
    RAM_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_ack_en",   32'(EN),   32'(0));
      check("late_ack_d_in", 32'(D_IN), 32'(8'hFF));
      @(negedge CLK);
    end

    // randomized slots
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = {12'h00F, 4'($urandom)};
        1:       ra = 16'hFFC0 | 16'($urandom_range(0, 63));
        2:       ra = {8'h01, 8'($urandom)};
        default: ra = 16'($urandom);
      endcase
      access(2'($urandom_range(0, 3)), ra, ra ^ 16'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, WT + 1),
             ($urandom_range(0, 7) == 0));
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
